led_pattern_engine: RTL and testbench

Parametrised LED pattern generator for the board LED bank: it drives N_LED outputs arranged as GROUPS groups of STRIDE columns. It offers four selectable animation modes, run/hold control, a two-speed step rate and a direction select. A single-clock design: an internal prescaler produces a step enable, so no derived clocks exist. It sits between the top-level switch/button inputs and the LED pins.

---
 rtl/led_pattern_pkg.sv | 41 ++++
 rtl/led_pattern_engine_tick.sv | 46 ++++
 rtl/led_pattern_engine.sv | 114 +++++++++++
 tb/tb_led_pattern_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings,
// column mask construction and per-mode phase counts.
package led_pattern_pkg;

    // Widest LED bank the column mask helper can describe.
    localparam int MAX_LED = 256;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FILL   = 2'd0;
    localparam mode_t MODE_CHASE  = 2'd1;
    localparam mode_t MODE_BOUNCE = 2'd2;
    localparam mode_t MODE_BLINK  = 2'd3;

    // Bits belonging to column c: led index i is in column (n_led-1-i) mod stride.
    function automatic logic [MAX_LED-1:0] column_mask(input int n_led, input int stride, input int c);
        logic [MAX_LED-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_LED; i++) begin
            if (i < n_led) begin
                if (((n_led - 1 - i) % stride) == c) begin
                    mask[i] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

    // Number of distinct phases each animation cycles through.
    function automatic int phase_count(input mode_t m, input int stride);
        int n;
        case (m)
            MODE_FILL:   n = stride + 2;
            MODE_CHASE:  n = stride;
            MODE_BOUNCE: n = 2 * stride - 2;
            default:     n = 2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_pattern_engine_tick.sv
// Prescaler that turns the system clock into a two-speed step enable.
// The limit compare is >= so a fast switch while the count is already past
// the fast limit steps on the next enabled edge instead of wrapping.
module led_step_tick #(
    parameter int FAST_DIV = 25,
    parameter int SLOW_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic speed,
    input  logic clear,
    output logic step_en
);

    localparam logic [63:0] FAST_LIM64 = (64'd1 << FAST_DIV) - 64'd1;
    localparam logic [63:0] SLOW_LIM64 = (64'd1 << SLOW_DIV) - 64'd1;
    localparam logic [SLOW_DIV-1:0] FAST_LIM = FAST_LIM64[SLOW_DIV-1:0];
    localparam logic [SLOW_DIV-1:0] SLOW_LIM = SLOW_LIM64[SLOW_DIV-1:0];

    if (FAST_DIV < 1 || FAST_DIV >= SLOW_DIV || SLOW_DIV > 32) begin : g_bad_div
        $error("led_step_tick: need 1 <= FAST_DIV < SLOW_DIV <= 32");
    end

    logic [SLOW_DIV-1:0] count;
    logic [SLOW_DIV-1:0] limit;

    assign limit   = speed ? FAST_LIM : SLOW_LIM;
    assign step_en = en && (count >= limit);

    // Count enabled cycles, restarting on a step, a clear strobe or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            if (step_en) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: four animations over GROUPS groups of STRIDE columns,
// stepped by an internal prescaler. Mode changes restart the animation at
// phase 0 on the very next edge.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int N_LED    = 16,
    parameter int GROUPS   = 4,
    parameter int FAST_DIV = 25,
    parameter int SLOW_DIV = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             speed,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [N_LED-1:0] led,
    output logic [7:0]       phase,
    output logic             step
);

    localparam int STRIDE = N_LED / GROUPS;

    if ((N_LED % GROUPS) != 0) begin : g_bad_groups
        $error("led_pattern_engine: N_LED must be a multiple of GROUPS");
    end
    if (STRIDE < 2) begin : g_bad_stride
        $error("led_pattern_engine: STRIDE must be at least 2");
    end
    if (N_LED > MAX_LED || STRIDE + 2 > 256) begin : g_bad_size
        $error("led_pattern_engine: LED bank too large");
    end

    mode_t      mode_q;
    logic       mode_change;
    logic       tick;
    logic [7:0] last_phase;
    logic [7:0] next_phase;

    assign mode_change = (mode != mode_q);
    assign last_phase  = 8'(phase_count(mode_q, STRIDE) - 1);
    assign next_phase  = (phase == last_phase) ? 8'd0 : phase + 8'd1;

    // LED image for a given mode, direction and phase.
    function automatic logic [N_LED-1:0] pattern(input mode_t m, input logic d, input logic [7:0] p);
        logic [N_LED-1:0] r;
        int pi;
        int target;
        r      = '0;
        pi     = {24'd0, p};
        target = (pi < STRIDE) ? pi : (2 * STRIDE - 2 - pi);
        for (int c = 0; c < STRIDE; c++) begin
            case (m)
                MODE_FILL: begin
                    if (pi >= 1 && pi <= STRIDE &&
                        ((!d && c < pi) || (d && c >= STRIDE - pi))) begin
                        r = r | N_LED'(column_mask(N_LED, STRIDE, c));
                    end
                end
                MODE_CHASE: begin
                    if ((!d && c == pi) || (d && c == STRIDE - 1 - pi)) begin
                        r = r | N_LED'(column_mask(N_LED, STRIDE, c));
                    end
                end
                MODE_BOUNCE: begin
                    if (c == target) begin
                        r = r | N_LED'(column_mask(N_LED, STRIDE, c));
                    end
                end
                default: begin
                    if (pi == 1) begin
                        r = '1;
                    end
                end
            endcase
        end
        return r;
    endfunction

    led_step_tick #(
        .FAST_DIV(FAST_DIV),
        .SLOW_DIV(SLOW_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .speed  (speed),
        .clear  (mode_change),
        .step_en(tick)
    );

    // Mode restart takes priority over a step; otherwise advance on each tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            led    <= '0;
            phase  <= 8'd0;
            step   <= 1'b0;
            mode_q <= mode;
        end else if (mode_change) begin
            mode_q <= mode;
            phase  <= 8'd0;
            led    <= pattern(mode, dir, 8'd0);
            step   <= 1'b0;
        end else if (tick) begin
            phase  <= next_phase;
            led    <= pattern(mode_q, dir, next_phase);
            step   <= 1'b1;
        end else begin
            step   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine with a behavioural reference model.
module tb_led_pattern_engine;

    localparam int N_LED    = 16;
    localparam int GROUPS   = 4;
    localparam int STRIDE   = N_LED / GROUPS;
    localparam int FAST_DIV = 2;
    localparam int SLOW_DIV = 3;

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] CHASE  = 2'd1;
    localparam logic [1:0] BOUNCE = 2'd2;
    localparam logic [1:0] BLINK  = 2'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             speed;
    logic [1:0]       mode;
    logic             dir;
    logic [N_LED-1:0] led;
    logic [7:0]       phase;
    logic             step;

    int checks = 0;
    int errors = 0;

    bit               m_valid = 1'b0;
    int               m_pre;
    int               m_phase;
    logic [N_LED-1:0] m_led;
    logic             m_step;
    logic [1:0]       m_mode;

    // Free-running system clock.
    always #5 clk = ~clk;

    led_pattern_engine #(
        .N_LED   (N_LED),
        .GROUPS  (GROUPS),
        .FAST_DIV(FAST_DIV),
        .SLOW_DIV(SLOW_DIV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .speed(speed),
        .mode (mode),
        .dir  (dir),
        .led  (led),
        .phase(phase),
        .step (step)
    );

    // One column: bit STRIDE-1-c of every group.
    function automatic logic [N_LED-1:0] col_bits(input int c);
        logic [N_LED-1:0] r;
        r = '0;
        for (int g = 0; g < GROUPS; g++) begin
            r = r | (N_LED'(1) << (g * STRIDE + (STRIDE - 1 - c)));
        end
        return r;
    endfunction

    function automatic int exp_count(input logic [1:0] m);
        case (m)
            FILL:    return STRIDE + 2;
            CHASE:   return STRIDE;
            BOUNCE:  return 2 * STRIDE - 2;
            default: return 2;
        endcase
    endfunction

    function automatic logic [N_LED-1:0] exp_pattern(input logic [1:0] m, input logic d, input int p);
        logic [N_LED-1:0] r;
        r = '0;
        case (m)
            FILL: begin
                if (p >= 1 && p <= STRIDE) begin
                    for (int k = 0; k < p; k++) begin
                        r = r | col_bits(d ? STRIDE - 1 - k : k);
                    end
                end
            end
            CHASE:   r = col_bits(d ? STRIDE - 1 - p : p);
            BOUNCE:  r = col_bits(p < STRIDE ? p : 2 * STRIDE - 2 - p);
            default: r = (p == 1) ? '1 : '0;
        endcase
        return r;
    endfunction

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: advances on the same edge as the DUT.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_led   = '0;
            m_phase = 0;
            m_step  = 1'b0;
            m_pre   = 0;
            m_mode  = mode;
        end else if (m_valid) begin
            if (mode != m_mode) begin
                m_mode  = mode;
                m_phase = 0;
                m_pre   = 0;
                m_led   = exp_pattern(mode, dir, 0);
                m_step  = 1'b0;
            end else if (en && m_pre >= (speed ? (1 << FAST_DIV) : (1 << SLOW_DIV)) - 1) begin
                m_pre   = 0;
                m_phase = (m_phase + 1) % exp_count(m_mode);
                m_led   = exp_pattern(m_mode, dir, m_phase);
                m_step  = 1'b1;
            end else begin
                if (en) m_pre = m_pre + 1;
                m_step = 1'b0;
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            compare("model_led", 32'(led), 32'(m_led));
            compare("model_phase", 32'(phase), 32'(m_phase));
            compare("model_step", 32'(step), 32'(m_step));
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic sp, input logic [1:0] m, input logic d);
        rst   = r;
        en    = e;
        speed = sp;
        mode  = m;
        dir   = d;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] exp_led, input int exp_phase, input logic exp_step);
        compare({name, "_led"}, 32'(led), 32'(exp_led));
        compare({name, "_phase"}, 32'(phase), 32'(exp_phase));
        compare({name, "_step"}, 32'(step), 32'(exp_step));
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] fill_led [7] = '{16'h8888, 16'hCCCC, 16'hEEEE, 16'hFFFF, 16'h0000, 16'h0000, 16'h8888};
    int          fill_ph  [7] = '{1, 2, 3, 4, 5, 0, 1};
    logic [15:0] chase_led[4] = '{16'h2222, 16'h4444, 16'h8888, 16'h1111};
    int          chase_ph [4] = '{1, 2, 3, 0};
    logic [15:0] bnc_led  [6] = '{16'h4444, 16'h2222, 16'h1111, 16'h2222, 16'h4444, 16'h8888};
    int          bnc_ph   [6] = '{1, 2, 3, 4, 5, 0};

    // Directed sequence with hand-computed expectations.
    initial begin
        applyStimulus(1'b1, 1'b0, 1'b1, FILL, 1'b0);
        waitCycles(3);
        checkOutput("reset", 16'h0000, 0, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b1, FILL, 1'b0);
        for (int k = 0; k < 3; k++) begin
            waitCycles(1);
            checkOutput("fill_wait", 16'h0000, 0, 1'b0);
        end
        for (int j = 0; j < 7; j++) begin
            if (j == 0) begin
                waitCycles(1);
            end else begin
                waitCycles(1);
                checkOutput("fill_step_low", fill_led[j-1], fill_ph[j-1], 1'b0);
                waitCycles(3);
            end
            checkOutput("fill_step", fill_led[j], fill_ph[j], 1'b1);
        end

        applyStimulus(1'b0, 1'b1, 1'b0, CHASE, 1'b1);
        waitCycles(1);
        checkOutput("chase_mode", 16'h1111, 0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            waitCycles(8);
            checkOutput("chase_step", chase_led[j], chase_ph[j], 1'b1);
        end

        applyStimulus(1'b0, 1'b1, 1'b1, BOUNCE, 1'b1);
        waitCycles(1);
        checkOutput("bounce_mode", 16'h8888, 0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            waitCycles(4);
            checkOutput("bounce_step", bnc_led[j], bnc_ph[j], 1'b1);
            if (j == 2) dir = 1'b0;
        end

        applyStimulus(1'b0, 1'b1, 1'b1, BLINK, 1'b0);
        waitCycles(1);
        checkOutput("blink_mode", 16'h0000, 0, 1'b0);
        waitCycles(2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            waitCycles(1);
            checkOutput("blink_hold", 16'h0000, 0, 1'b0);
        end
        en = 1'b1;
        waitCycles(1);
        checkOutput("blink_resume", 16'h0000, 0, 1'b0);
        waitCycles(1);
        checkOutput("blink_on", 16'hFFFF, 1, 1'b1);
        waitCycles(4);
        checkOutput("blink_off", 16'h0000, 0, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b0, FILL, 1'b0);
        waitCycles(1);
        checkOutput("speed_mode", 16'h0000, 0, 1'b0);
        waitCycles(6);
        speed = 1'b1;
        waitCycles(1);
        checkOutput("speed_switch", 16'h8888, 1, 1'b1);
        waitCycles(4);
        checkOutput("speed_fast1", 16'hCCCC, 2, 1'b1);
        waitCycles(4);
        checkOutput("speed_fast2", 16'hEEEE, 3, 1'b1);

        waitCycles(2);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("mid_reset", 16'h0000, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, FILL, 1'b0);
        for (int k = 0; k < 3; k++) begin
            waitCycles(1);
            checkOutput("post_reset_wait", 16'h0000, 0, 1'b0);
        end
        waitCycles(1);
        checkOutput("post_reset_step", 16'h8888, 1, 1'b1);

        waitCycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
